// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 serial receiver with mid-bit sampling.
// Emits one-cycle rx_flag per good byte, frame_err on low stop bit.
module uart_rx_byte #(
   parameter int unsigned BAUD_END = 5207,
   parameter int unsigned BIT_MID  = 2603
) (
   input  logic       sclk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_flag,
   output logic       frame_err
);

   localparam logic [12:0] L_END = 13'(BAUD_END);
   localparam logic [12:0] L_MID = 13'(BIT_MID);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        r_rx1;
   logic        r_rx2;
   logic        r_rx3;
   logic [12:0] r_baud_cnt;
   logic [2:0]  r_bit_cnt;
   logic [7:0]  r_shift;
   logic [7:0]  r_rx_data;
   logic        r_rx_flag;
   logic        r_frame_err;

   logic        w_start_edge;
   logic        w_mid;
   logic        w_end;
   logic        w_shift_en;
   logic        w_load;
   logic        w_err;
   logic        w_bit_inc;
   logic        w_bit_clr;

   assign w_start_edge = ~r_rx2 & r_rx3;
   assign w_mid        = (r_baud_cnt == L_MID);
   assign w_end        = (r_baud_cnt == L_END);

   // Three-flop synchronizer; rx2 is the sampled line, rx3 its history.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx1 <= 1'b1;
         r_rx2 <= 1'b1;
         r_rx3 <= 1'b1;
      end else begin
         r_rx1 <= rx;
         r_rx2 <= r_rx1;
         r_rx3 <= r_rx2;
      end
   end

   // State register.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and per-cycle action decode.
   always_comb begin
      w_next     = r_state;
      w_shift_en = 1'b0;
      w_load     = 1'b0;
      w_err      = 1'b0;
      w_bit_inc  = 1'b0;
      w_bit_clr  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_start_edge) begin
               w_next = S_START;
            end
         end
         S_START: begin
            w_bit_clr = 1'b1;
            if (w_mid && r_rx2) begin
               w_next = S_IDLE;
            end else if (w_end) begin
               w_next = S_DATA;
            end
         end
         S_DATA: begin
            w_shift_en = w_mid;
            if (w_end) begin
               w_bit_inc = 1'b1;
               if (r_bit_cnt == 3'd7) begin
                  w_next = S_STOP;
               end
            end
         end
         S_STOP: begin
            // Leave at mid-stop so a back-to-back start edge is caught.
            if (w_mid) begin
               w_next = S_IDLE;
               w_load = r_rx2;
               w_err  = ~r_rx2;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Baud counter: held at 0 in IDLE, wraps after BAUD_END.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         r_baud_cnt <= '0;
      end else if (r_state == S_IDLE || w_next == S_IDLE || w_end) begin
         r_baud_cnt <= '0;
      end else begin
         r_baud_cnt <= r_baud_cnt + 13'd1;
      end
   end

   // Data bit counter.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_cnt <= '0;
      end else if (w_bit_clr) begin
         r_bit_cnt <= '0;
      end else if (w_bit_inc) begin
         r_bit_cnt <= r_bit_cnt + 3'd1;
      end
   end

   // LSB-first shift register, filled at mid-bit.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         r_shift <= '0;
      end else if (w_shift_en) begin
         r_shift <= {r_rx2, r_shift[7:1]};
      end
   end

   // Registered outputs: byte latch and one-cycle strobes.
   always_ff @(posedge sclk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_data   <= 8'h00;
         r_rx_flag   <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_flag   <= w_load;
         r_frame_err <= w_err;
         if (w_load) begin
            r_rx_data <= r_shift;
         end
      end
   end

   assign rx_data   = r_rx_data;
   assign rx_flag   = r_rx_flag;
   assign frame_err = r_frame_err;

endmodule

// File: doc/uart_rx_byte.md
# uart_rx_byte

Asynchronous serial receiver that turns the 8N1 UART line from the host into a byte stream. Each byte is presented on `rx_data` with a single-cycle `rx_flag` strobe. It sits directly upstream of the frame controller, which parses the header (`55`×7, `D5`, `FA`, `AA`/`55`, `00`, `00`) and the 40000-byte pixel payload from this stream. Line rate is 9600 baud from the 50 MHz system clock.

## Interface
- `BAUD_END`, 5207: last count of one bit period (clock cycles per bit − 1).
- `BIT_MID`, 2603: baud count at which a bit is sampled (mid-bit).
- `sclk`  in  1  system clock, 50 MHz; all logic on its rising edge.
- `rst_n`  in  1  reset; one clock, asynchronous, active-low.
- `rx`  in  1  raw serial line, idle high, asynchronous to `sclk`.
- `rx_data`  out  8  last correctly framed byte; LSB received first.
- `rx_flag`  out  1  one-cycle strobe; `rx_data` is valid in the same cycle.
- `frame_err`  out  1  one-cycle strobe when the stop bit samples low.

## Operation
- **Synchronizer.** `rx` passes through three flops `rx1→rx2→rx3`, all reset to 1.
  - `rx2` is the sampled line value.
  - A start edge is `rx2==0 && rx3==1`.
- **FSM states.** IDLE, START, DATA, STOP.
  - IDLE: on a start edge → START; `baud_cnt` is cleared.
  - START: at `baud_cnt==BIT_MID`, if `rx2==1` → IDLE (glitch/false start, no strobe). Otherwise the FSM stays in START until `baud_cnt==BAUD_END`, then → DATA with `bit_cnt=0`.
  - DATA: at `BIT_MID`, shift `shift <= {rx2, shift[7:1]}`. At `BAUD_END`, `bit_cnt++`. After the `BAUD_END` of bit 7 → STOP.
  - STOP: at `BIT_MID`, sample `rx2`.
    - High: `rx_data <= shift` and pulse `rx_flag`.
    - Low: pulse `frame_err`; `rx_data` is unchanged.
    - Either way → IDLE at that same sample point. The second half of the stop bit is not waited out, which allows resync to a back-to-back start bit.
- **Counters.**
  - `baud_cnt`: 13 bits; counts 0..`BAUD_END` and wraps to 0. It is held at 0 in IDLE.
  - `bit_cnt`: 3 bits; counts 0..7.
- **Continuous low (break).** Received as a byte of `00` with `frame_err`. No new frame starts until the line has been seen high and then falls again, because edge detection requires `rx3==1`.
- **`rx_data` hold.** `rx_data` holds its value between strobes. `rx_flag` and `frame_err` are never high in the same cycle.

## Timing
- **Reset values.** `rx_data=8'h00`, `rx_flag=0`, `frame_err=0`, state IDLE, counters 0, synchronizer 1.
- **Reset mid-frame.** The partial byte is discarded and no strobe is produced. Reception restarts at the next falling edge.
- **Edge-to-START latency.** The `rx` fall reaches `rx2` after 2 clocks. The edge is detected in that cycle and START is entered on the next clock with `baud_cnt=0`.
- **Sample points.** Bit k (start=0, data 1..8, stop=9) is sampled `k·(BAUD_END+1)+BIT_MID` cycles after START entry. With defaults, the stop sample is at cycle 49475.
- **Strobe timing.** `rx_flag`/`frame_err` are registered and high in the cycle after the stop sample, for exactly one cycle.
- **Byte spacing.** The minimum spacing between consecutive `rx_flag` strobes is one full frame (52080 cycles at nominal rate). The block tolerates a sender faster by up to ±4 %.

## Test plan
- **Single byte.**
  - Stimulus: reset, line idle high for 10 bit times, send `0x55` (8N1, 5208 cycles/bit).
  - Required response: exactly one `rx_flag` pulse, `rx_data=8'h55`, no `frame_err`.
- **Header stream.**
  - Stimulus: send `55`×7, `D5`, `FA`, `AA`, `00`, `00`, `A5` back-to-back with no idle.
  - Required response: 13 `rx_flag` pulses with matching bytes in order, spaced 52080±3 cycles.
- **False start.**
  - Stimulus: drive `rx` low for 1000 cycles, then high.
  - Required response: FSM returns to IDLE; no `rx_flag`, no `frame_err`. A following `0x3C` is received correctly.
- **Framing error.**
  - Stimulus: receive `0x81` correctly, then send `0xF0` with the stop bit forced low.
  - Required response: one `frame_err` pulse, no `rx_flag`, `rx_data` stays `8'h81`.
  - Then: line high, send `0x0F` → `rx_flag` with `rx_data=8'h0F`.
- **Reset mid-frame.**
  - Stimulus: assert `rst_n=0` during data bit 4 of `0xC3`, release, send `0x5A`.
  - Required response: all outputs 0 while in reset; no strobe for the aborted byte; then `rx_flag` with `rx_data=8'h5A`.
- **Break.**
  - Stimulus: hold `rx` low for 30 bit times, then release high and send `0x7E`.
  - Required response: one `frame_err` during the break, no further strobes, then `rx_flag` with `rx_data=8'h7E`.
